ad7621_capture: RTL and testbench

Per-pixel conversion sequencer and pixel conditioner between the ILX511B readout timing and the CCD FIFO. Each pixel-start pulse drives one AD7621 conversion (CONVST/BUSY handshake) and latches the 16-bit result. It subtracts the dark offset, clamps to the saturation ceiling and drops the leading dummy pixels. Each surviving pixel goes to the FIFO write port as a one-cycle strobe, with frame bookkeeping and sticky error flags for the MCU.

---
 rtl/ad7621_capture.sv | 147 ++++++++++++++
 tb/tb_ad7621_capture.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/ad7621_capture.sv
// AD7621 per-pixel conversion sequencer: drives CONVST/BUSY, latches the sample,
// subtracts the dark offset, clamps to saturation and streams surviving pixels to the CCD FIFO.
module ad7621_capture #(
  parameter int CONVST_LOW   = 4,
  parameter int BUSY_TIMEOUT = 96,
  parameter int SKIP_PIXELS  = 32,
  parameter int N_PIXELS     = 2048
) (
  input  logic        sys_clk,
  input  logic        sys_rst,
  input  logic        frame_restart,
  input  logic        pixel_start,
  input  logic [15:0] FPGA_OFFSETVALUE,
  input  logic [15:0] FPGA_MAXSATVALUE,
  input  logic        ad7621_busy,
  input  logic [15:0] ad7621_di,
  output logic        ad7621_convst,
  output logic [15:0] fifo_do,
  output logic        flag_fifo_do,
  output logic        frame_done,
  output logic        overrun,
  output logic        busy_timeout
);

  localparam int CNT_MAX = (CONVST_LOW > BUSY_TIMEOUT) ? CONVST_LOW : BUSY_TIMEOUT;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);

  localparam logic [CNT_W-1:0] CONV_LAST = CNT_W'(CONVST_LOW - 1);
  localparam logic [CNT_W-1:0] WAIT_LAST = CNT_W'(BUSY_TIMEOUT - 1);
  localparam logic [11:0]      PIX_FIRST = 12'(SKIP_PIXELS);
  localparam logic [11:0]      PIX_LAST  = 12'(SKIP_PIXELS + N_PIXELS - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CONV,
    S_WAIT_H,
    S_WAIT_L,
    S_LATCH,
    S_PROC
  } state_t;

  state_t           r_state;
  state_t           w_next;
  logic [CNT_W-1:0] r_cnt;
  logic             r_busy_m;
  logic             r_busy_s;
  logic             r_active;
  logic [11:0]      r_pix_cnt;
  logic [15:0]      r_raw;
  logic             w_timeout;
  logic [16:0]      w_diff;
  logic [15:0]      w_sub;
  logic [15:0]      w_pix;
  logic             w_in_window;

  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    w_next    = r_state;
    w_timeout = 1'b0;
    unique case (r_state)
      S_IDLE:   if (pixel_start && r_active) w_next = S_CONV;
      S_CONV:   if (r_cnt == CONV_LAST) w_next = S_WAIT_H;
      S_WAIT_H: begin
        if (r_busy_s) begin
          w_next = S_WAIT_L;
        end else if (r_cnt == WAIT_LAST) begin
          w_next    = S_PROC;
          w_timeout = 1'b1;
        end
      end
      S_WAIT_L: if (!r_busy_s) w_next = S_LATCH;
      S_LATCH:  w_next = S_PROC;
      S_PROC:   w_next = S_IDLE;
      default:  w_next = S_IDLE;
    endcase
    if (frame_restart) begin
      w_next    = S_IDLE;
      w_timeout = 1'b0;
    end
  end

  // Dark subtraction floors at zero; a zero ceiling disables clamping.
  always_comb begin
    w_diff      = {1'b0, r_raw} - {1'b0, FPGA_OFFSETVALUE};
    w_sub       = (r_raw > FPGA_OFFSETVALUE) ? w_diff[15:0] : 16'd0;
    w_pix       = ((FPGA_MAXSATVALUE != 16'd0) && (w_sub > FPGA_MAXSATVALUE)) ? FPGA_MAXSATVALUE : w_sub;
    w_in_window = (r_pix_cnt >= PIX_FIRST) && (r_pix_cnt <= PIX_LAST);
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge sys_clk or negedge sys_rst) begin
    if (!sys_rst) begin
      r_state       <= S_IDLE;
      r_cnt         <= '0;
      r_busy_m      <= 1'b0;
      r_busy_s      <= 1'b0;
      r_active      <= 1'b0;
      r_pix_cnt     <= '0;
      r_raw         <= '0;
      ad7621_convst <= 1'b1;
      fifo_do       <= '0;
      flag_fifo_do  <= 1'b0;
      frame_done    <= 1'b0;
      overrun       <= 1'b0;
      busy_timeout  <= 1'b0;
    end else begin
      r_busy_m      <= ad7621_busy;
      r_busy_s      <= r_busy_m;
      r_state       <= w_next;
      flag_fifo_do  <= 1'b0;
      frame_done    <= 1'b0;
      ad7621_convst <= frame_restart || (r_state != S_CONV);

      if (w_next != r_state) begin
        r_cnt <= '0;
      end else if (r_state == S_CONV || r_state == S_WAIT_H) begin
        r_cnt <= r_cnt + 1'b1;
      end

      if (frame_restart) begin
        r_pix_cnt    <= '0;
        r_active     <= 1'b1;
        overrun      <= 1'b0;
        busy_timeout <= 1'b0;
      end else begin
        if (pixel_start && r_state != S_IDLE) overrun <= 1'b1;
        if (w_timeout) begin
          busy_timeout <= 1'b1;
          r_raw        <= '0;
        end
        if (r_state == S_LATCH) r_raw <= ad7621_di;
        if (r_state == S_PROC) begin
          r_pix_cnt <= r_pix_cnt + 1'b1;
          if (w_in_window) begin
            fifo_do      <= w_pix;
            flag_fifo_do <= 1'b1;
          end
          if (r_pix_cnt == PIX_LAST) begin
            frame_done <= 1'b1;
            r_active   <= 1'b0;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_ad7621_capture.sv
// Directed bench for ad7621_capture: a behavioural AD7621 model answers CONVST,
// and a monitor counts strobes and convst pulses against hand-computed expectations.
module tb_ad7621_capture;

  localparam int CONVST_LOW   = 4;
  localparam int BUSY_TIMEOUT = 96;
  localparam int SKIP_PIXELS  = 32;
  localparam int N_PIXELS     = 2048;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        frame_restart;
  logic        pixel_start;
  logic [15:0] offset;
  logic [15:0] maxsat;
  logic        busy;
  logic [15:0] di;
  logic        convst;
  logic [15:0] fifo_do;
  logic        flag_fifo_do;
  logic        frame_done;
  logic        overrun;
  logic        busy_timeout;

  int vectors     = 0;
  int miscompares = 0;

  // Model and monitor state
  int          busy_hi = 2;
  bit          adc_en  = 1'b1;
  int          bcnt    = 0;
  logic        cv_q    = 1'b1;
  int          falls   = 0;
  int          strobes = 0;
  int          bad     = 0;
  int          fd_cnt  = 0;
  int          fd_at   = 0;
  logic [15:0] exp_do  = '0;
  logic [15:0] last_do = '0;

  ad7621_capture #(
    .CONVST_LOW  (CONVST_LOW),
    .BUSY_TIMEOUT(BUSY_TIMEOUT),
    .SKIP_PIXELS (SKIP_PIXELS),
    .N_PIXELS    (N_PIXELS)
  ) dut (
    .sys_clk         (clk),
    .sys_rst         (rst_n),
    .frame_restart   (frame_restart),
    .pixel_start     (pixel_start),
    .FPGA_OFFSETVALUE(offset),
    .FPGA_MAXSATVALUE(maxsat),
    .ad7621_busy     (busy),
    .ad7621_di       (di),
    .ad7621_convst   (convst),
    .fifo_do         (fifo_do),
    .flag_fifo_do    (flag_fifo_do),
    .frame_done      (frame_done),
    .overrun         (overrun),
    .busy_timeout    (busy_timeout)
  );

  always #10 clk = ~clk;

  // ADC: BUSY rises half a cycle after CONVST rises and stays high busy_hi cycles.
  always @(negedge clk) begin
    if (bcnt > 0) begin
      bcnt = bcnt - 1;
      if (bcnt == 0) busy = 1'b0;
    end else if (adc_en && !cv_q && convst) begin
      busy = 1'b1;
      bcnt = busy_hi;
    end
    if (cv_q && !convst) falls = falls + 1;
    cv_q = convst;
    if (flag_fifo_do) begin
      strobes = strobes + 1;
      last_do = fifo_do;
      if (fifo_do != exp_do) bad = bad + 1;
    end
    if (frame_done) begin
      fd_cnt = fd_cnt + 1;
      fd_at  = flag_fifo_do ? strobes : -1;
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic pulse_pixel();
    pixel_start = 1'b1;
    @(negedge clk);
    pixel_start = 1'b0;
  endtask

  task automatic pulse_restart();
    frame_restart = 1'b1;
    @(negedge clk);
    frame_restart = 1'b0;
  endtask

  task automatic run_pixels(input int n);
    for (int i = 0; i < n; i++) begin
      pulse_pixel();
      repeat (CONVST_LOW + busy_hi + 12) @(negedge clk);
    end
  endtask

  // One in-window pixel with a given sample and settings.
  task automatic one_pixel(input string tag, input logic [15:0] d, input logic [15:0] off,
                           input logic [15:0] ms, input logic [15:0] exp);
    int s0;
    di     = d;
    offset = off;
    maxsat = ms;
    exp_do = exp;
    s0     = strobes;
    run_pixels(1);
    check({tag, "_strobe"}, strobes - s0, 1);
    check({tag, "_data"}, last_do, exp);
  endtask

  initial begin
    int s0, b0, f0;
    rst_n         = 1'b0;
    frame_restart = 1'b0;
    pixel_start   = 1'b0;
    offset        = 16'd100;
    maxsat        = 16'd0;
    busy          = 1'b0;
    di            = 16'd1000;
    repeat (3) @(negedge clk);
    check("rst_convst", convst, 1);
    check("rst_fifo_do", fifo_do, 0);
    check("rst_flag", flag_fifo_do, 0);
    check("rst_frame_done", frame_done, 0);
    check("rst_overrun", overrun, 0);
    check("rst_busy_timeout", busy_timeout, 0);
    rst_n = 1'b1;
    @(negedge clk);

    // Frame inactive after reset: pixel_start ignored, no overrun.
    f0 = falls;
    run_pixels(1);
    check("inactive_no_conv", falls - f0, 0);
    check("inactive_no_overrun", overrun, 0);

    // Full frame, OFFSET=100, di=1000 -> 900; first pixels use a 30-cycle busy.
    pulse_restart();
    exp_do  = 16'd900;
    s0      = strobes;
    b0      = bad;
    f0      = falls;
    busy_hi = 30;
    run_pixels(2);
    busy_hi = 2;
    run_pixels(SKIP_PIXELS - 2);
    check("skip_no_strobe", strobes - s0, 0);
    check("skip_convs", falls - f0, SKIP_PIXELS);
    run_pixels(N_PIXELS);
    check("frame_strobes", strobes - s0, N_PIXELS);
    check("frame_bad_data", bad - b0, 0);
    check("frame_done_count", fd_cnt, 1);
    check("frame_done_at", fd_at, s0 + N_PIXELS);
    check("frame_last_do", last_do, 900);
    f0 = falls;
    run_pixels(1);
    check("after_done_no_conv", falls - f0, 0);
    check("after_done_no_overrun", overrun, 0);

    // Arithmetic vectors inside the write window.
    pulse_restart();
    exp_do = 16'd900;
    run_pixels(SKIP_PIXELS);
    one_pixel("floor", 16'd300, 16'd500, 16'd0, 16'd0);
    one_pixel("clamp_full", 16'd65535, 16'd0, 16'd40000, 16'd40000);
    one_pixel("clamp_eq", 16'd40000, 16'd0, 16'd40000, 16'd40000);
    one_pixel("clamp_below", 16'd39999, 16'd0, 16'd40000, 16'd39999);
    one_pixel("off_eq", 16'd100, 16'd100, 16'd0, 16'd0);
    one_pixel("off_plus1", 16'd101, 16'd100, 16'd0, 16'd1);
    one_pixel("sub_then_clamp", 16'd1000, 16'd100, 16'd5, 16'd5);

    // Busy never rises: timeout, zero pixel still written.
    adc_en = 1'b0;
    exp_do = 16'd0;
    s0     = strobes;
    pulse_pixel();
    repeat (CONVST_LOW + BUSY_TIMEOUT + 14) @(negedge clk);
    check("timeout_flag", busy_timeout, 1);
    check("timeout_strobe", strobes - s0, 1);
    check("timeout_data", last_do, 0);
    adc_en = 1'b1;
    one_pixel("post_timeout", 16'd1234, 16'd0, 16'd0, 16'd1234);
    check("timeout_sticky", busy_timeout, 1);
    pulse_restart();
    check("timeout_cleared", busy_timeout, 0);

    // Second pixel_start 3 cycles after the first.
    f0 = falls;
    pulse_pixel();
    repeat (2) @(negedge clk);
    pulse_pixel();
    repeat (CONVST_LOW + busy_hi + 14) @(negedge clk);
    check("overrun_set", overrun, 1);
    check("overrun_one_conv", falls - f0, 1);
    pulse_restart();
    check("overrun_cleared", overrun, 0);

    // Restart while waiting for busy to fall.
    busy_hi = 30;
    s0      = strobes;
    pulse_pixel();
    repeat (14) @(negedge clk);
    pulse_restart();
    check("abort_convst", convst, 1);
    repeat (45) @(negedge clk);
    check("abort_no_strobe", strobes - s0, 0);
    busy_hi = 2;
    exp_do  = 16'd1234;
    run_pixels(SKIP_PIXELS);
    check("abort_pix0_skipped", strobes - s0, 0);
    run_pixels(1);
    check("abort_first_write", strobes - s0, 1);

    // Async reset during CONV.
    pulse_restart();
    pulse_pixel();
    pulse_pixel();
    check("conv_low_before_rst", convst, 0);
    check("overrun_before_rst", overrun, 1);
    #1 rst_n = 1'b0;
    #1;
    check("arst_convst", convst, 1);
    check("arst_fifo_do", fifo_do, 0);
    check("arst_overrun", overrun, 0);
    check("arst_flag", flag_fifo_do, 0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (40) @(negedge clk);
    f0 = falls;
    s0 = strobes;
    run_pixels(1);
    check("arst_pixel_ignored", falls - f0, 0);
    check("arst_no_strobe", strobes - s0, 0);
    pulse_restart();
    run_pixels(SKIP_PIXELS);
    one_pixel("arst_recover", 16'd777, 16'd0, 16'd0, 16'd777);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
